// File: rtl/pipeline_pkg.sv
// Shared constants and types for the 8-bit pipeline hazard controller.
// Forwarding selects, opcodes and controller FSM state.
package pipeline_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [3:0] OPC_ADD  = 4'b0000;
    localparam logic [3:0] OPC_LOAD = 4'b1000;
    localparam logic [3:0] OPC_MUL  = 4'b1011;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        MULTI = 1'b1
    } ctrl_state_t;

    // MULTI dwell length: the start cycle is spent in RUN, so MULTI
    // covers the remaining MUL_LAT-2 stall cycles (at least one).
    function automatic logic [3:0] mul_cnt_init(input int lat);
        if (lat > 2) begin
            return 4'(lat - 2);
        end
        return 4'd1;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_forward_unit.sv
// Combinational EX operand forwarding select generation.
// MEM result beats WB result; R0 is never forwarded.
module forward_unit
    import pipeline_pkg::*;
#(
    parameter int REG_AW = 3
) (
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              mem_regwrite,
    input  logic              wb_regwrite,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b
);

    logic mem_ok;
    logic wb_ok;

    assign mem_ok = mem_regwrite && (mem_rd != '0);
    assign wb_ok  = wb_regwrite && (wb_rd != '0);

    // Per-operand select with MEM over WB priority
    always_comb begin
        forward_a = FWD_REG;
        forward_b = FWD_REG;
        if (mem_ok && (mem_rd == ex_rs1)) begin
            forward_a = FWD_MEM;
        end else if (wb_ok && (wb_rd == ex_rs1)) begin
            forward_a = FWD_WB;
        end
        if (mem_ok && (mem_rd == ex_rs2)) begin
            forward_b = FWD_MEM;
        end else if (wb_ok && (wb_rd == ex_rs2)) begin
            forward_b = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller: forwarding, load-use stall, branch flush, MUL FSM.
// Optional perf counters enabled by defining HAZARD_CTRL_PERF_EN.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int               REG_AW     = 3,
    parameter int               OPC_W      = 4,
    parameter logic [OPC_W-1:0] MUL_OPCODE = OPC_MUL,
    parameter int               MUL_LAT    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              ex_valid,
    input  logic [OPC_W-1:0]  ex_opcode,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_memread,
    input  logic              ex_branch_taken,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              mem_regwrite,
    input  logic              wb_regwrite,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              id_ex_en,
    output logic              pc_sel_branch,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic              ex_mem_bubble,
    output logic              alu_start,
    output logic              busy
`ifdef HAZARD_CTRL_PERF_EN
    ,
    output logic [15:0]       perf_stall_cnt,
    output logic [15:0]       perf_flush_cnt,
    output logic [15:0]       perf_mul_cnt
`endif
);

    localparam logic [3:0] CNT_INIT = mul_cnt_init(MUL_LAT);

    ctrl_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic [3:0]  fwd_hold_q, fwd_hold_d;

    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        load_use;
    logic        mul_hit;

    forward_unit #(
        .REG_AW (REG_AW)
    ) u_fwd (
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .mem_rd       (mem_rd),
        .wb_rd        (wb_rd),
        .mem_regwrite (mem_regwrite),
        .wb_regwrite  (wb_regwrite),
        .forward_a    (fwd_a),
        .forward_b    (fwd_b)
    );

    assign load_use = ex_valid && ex_memread && (ex_rd != '0)
                   && ((id_use_rs1 && (id_rs1 == ex_rd))
                    || (id_use_rs2 && (id_rs2 == ex_rd)));

    // done_q masks the MUL still sitting in EX the cycle after it finished
    assign mul_hit = ex_valid && (ex_opcode == MUL_OPCODE)
                  && !ex_branch_taken && !done_q;

    // Next-state and pipeline control; everything reads 0 during reset
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        done_d        = 1'b0;
        fwd_hold_d    = fwd_hold_q;
        forward_a     = FWD_REG;
        forward_b     = FWD_REG;
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        pc_sel_branch = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        alu_start     = 1'b0;
        busy          = 1'b0;
        if (!rst_n) begin
            state_d    = RUN;
            cnt_d      = 4'd0;
            fwd_hold_d = 4'd0;
        end else begin
            case (state_q)
                MULTI: begin
                    busy      = 1'b1;
                    forward_a = fwd_hold_q[3:2];
                    forward_b = fwd_hold_q[1:0];
                    if (cnt_q <= 4'd1) begin
                        state_d = RUN;
                        cnt_d   = 4'd0;
                        done_d  = 1'b1;
                    end else begin
                        ex_mem_bubble = 1'b1;
                        cnt_d         = cnt_q - 4'd1;
                    end
                end
                default: begin
                    forward_a = fwd_a;
                    forward_b = fwd_b;
                    pc_en     = 1'b1;
                    if_id_en  = 1'b1;
                    id_ex_en  = 1'b1;
                    if (ex_branch_taken) begin
                        pc_sel_branch = 1'b1;
                        if_id_flush   = 1'b1;
                        id_ex_bubble  = 1'b1;
                    end else if (mul_hit) begin
                        alu_start     = 1'b1;
                        pc_en         = 1'b0;
                        if_id_en      = 1'b0;
                        id_ex_en      = 1'b0;
                        ex_mem_bubble = 1'b1;
                        state_d       = MULTI;
                        cnt_d         = CNT_INIT;
                        fwd_hold_d    = {fwd_a, fwd_b};
                    end else if (load_use) begin
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_bubble = 1'b1;
                    end
                end
            endcase
        end
    end

    // Controller state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            cnt_q      <= 4'd0;
            done_q     <= 1'b0;
            fwd_hold_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            fwd_hold_q <= fwd_hold_d;
        end
    end

`ifdef HAZARD_CTRL_PERF_EN
    logic [15:0] perf_stall_q, perf_stall_d;
    logic [15:0] perf_flush_q, perf_flush_d;
    logic [15:0] perf_mul_q, perf_mul_d;

    // Saturating event counters
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        perf_mul_d   = perf_mul_q;
        if (rst_n && !pc_en && (perf_stall_q != 16'hFFFF)) begin
            perf_stall_d = perf_stall_q + 16'd1;
        end
        if (pc_sel_branch && (perf_flush_q != 16'hFFFF)) begin
            perf_flush_d = perf_flush_q + 16'd1;
        end
        if (alu_start && (perf_mul_q != 16'hFFFF)) begin
            perf_mul_d = perf_mul_q + 16'd1;
        end
    end

    // Counter registers, cleared by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stall_q <= 16'd0;
            perf_flush_q <= 16'd0;
            perf_mul_q   <= 16'd0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
            perf_mul_q   <= perf_mul_d;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
    assign perf_mul_cnt   = perf_mul_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (MUL_LAT=4).
// Perf counter checks compile only with HAZARD_CTRL_PERF_EN.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] id_rs1, id_rs2;
    logic       id_use_rs1, id_use_rs2;
    logic       ex_valid;
    logic [3:0] ex_opcode;
    logic [2:0] ex_rs1, ex_rs2, ex_rd;
    logic       ex_memread, ex_branch_taken;
    logic [2:0] mem_rd, wb_rd;
    logic       mem_regwrite, wb_regwrite;
    logic [1:0] forward_a, forward_b;
    logic       pc_en, if_id_en, id_ex_en, pc_sel_branch;
    logic       if_id_flush, id_ex_bubble, ex_mem_bubble;
    logic       alu_start, busy;
`ifdef HAZARD_CTRL_PERF_EN
    logic [15:0] perf_stall_cnt, perf_flush_cnt, perf_mul_cnt;
`endif

    int checks = 0;
    int fails  = 0;

    // pc_en if_id_en id_ex_en pc_sel flush id_bub ex_bub start busy
    logic [8:0] ctl;
    assign ctl = {pc_en, if_id_en, id_ex_en, pc_sel_branch, if_id_flush,
                  id_ex_bubble, ex_mem_bubble, alu_start, busy};

    localparam logic [8:0] C_RUN   = 9'b111000000;
    localparam logic [8:0] C_BR    = 9'b111111000;
    localparam logic [8:0] C_LU    = 9'b001001000;
    localparam logic [8:0] C_START = 9'b000000110;
    localparam logic [8:0] C_MBUB  = 9'b000000101;
    localparam logic [8:0] C_MLAST = 9'b000000001;
    localparam logic [8:0] C_ZERO  = 9'b000000000;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_valid        (ex_valid),
        .ex_opcode       (ex_opcode),
        .ex_rs1          (ex_rs1),
        .ex_rs2          (ex_rs2),
        .ex_rd           (ex_rd),
        .ex_memread      (ex_memread),
        .ex_branch_taken (ex_branch_taken),
        .mem_rd          (mem_rd),
        .wb_rd           (wb_rd),
        .mem_regwrite    (mem_regwrite),
        .wb_regwrite     (wb_regwrite),
        .forward_a       (forward_a),
        .forward_b       (forward_b),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .id_ex_en        (id_ex_en),
        .pc_sel_branch   (pc_sel_branch),
        .if_id_flush     (if_id_flush),
        .id_ex_bubble    (id_ex_bubble),
        .ex_mem_bubble   (ex_mem_bubble),
        .alu_start       (alu_start),
        .busy            (busy)
`ifdef HAZARD_CTRL_PERF_EN
        ,
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_flush_cnt  (perf_flush_cnt),
        .perf_mul_cnt    (perf_mul_cnt)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        id_rs1 = 3'd0; id_rs2 = 3'd0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_valid = 1'b0; ex_opcode = 4'b0000;
        ex_rs1 = 3'd0; ex_rs2 = 3'd0; ex_rd = 3'd0;
        ex_memread = 1'b0; ex_branch_taken = 1'b0;
        mem_rd = 3'd0; wb_rd = 3'd0;
        mem_regwrite = 1'b0; wb_regwrite = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle();
        ex_rs1 = 3'd3; mem_rd = 3'd3; mem_regwrite = 1'b1;
        ex_branch_taken = 1'b1;
        tick(); tick();
        checks++;
        if (ctl !== C_ZERO) begin
            fails++;
            $display("FAIL reset_ctl got=%b exp=%b", ctl, C_ZERO);
        end
        checks++;
        if ({forward_a, forward_b} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_fwd got=%b exp=0000", {forward_a, forward_b});
        end
        rst_n = 1'b1;
        idle();
        #1;
        checks++;
        if (ctl !== C_RUN) begin
            fails++;
            $display("FAIL post_reset_run got=%b exp=%b", ctl, C_RUN);
        end
        tick();
    endtask

    task automatic test_forwarding;
        idle();
        ex_valid = 1'b1;
        ex_rs1 = 3'd3; mem_rd = 3'd3; mem_regwrite = 1'b1;
        wb_rd = 3'd3; wb_regwrite = 1'b1;
        #1;
        checks++;
        if (forward_a !== 2'b10) begin
            fails++;
            $display("FAIL fwd_a_mem got=%b exp=10", forward_a);
        end
        mem_regwrite = 1'b0;
        #1;
        checks++;
        if (forward_a !== 2'b01) begin
            fails++;
            $display("FAIL fwd_a_wb got=%b exp=01", forward_a);
        end
        ex_rs1 = 3'd0; mem_rd = 3'd0; wb_rd = 3'd0;
        mem_regwrite = 1'b1;
        #1;
        checks++;
        if (forward_a !== 2'b00) begin
            fails++;
            $display("FAIL fwd_a_r0 got=%b exp=00", forward_a);
        end
        ex_rs1 = 3'd1; ex_rs2 = 3'd5;
        mem_rd = 3'd6; mem_regwrite = 1'b1;
        wb_rd = 3'd5; wb_regwrite = 1'b1;
        #1;
        checks++;
        if ({forward_a, forward_b} !== 4'b0001) begin
            fails++;
            $display("FAIL fwd_b_wb got=%b exp=0001", {forward_a, forward_b});
        end
        mem_rd = 3'd5;
        #1;
        checks++;
        if ({forward_a, forward_b} !== 4'b0010) begin
            fails++;
            $display("FAIL fwd_b_mem got=%b exp=0010", {forward_a, forward_b});
        end
        checks++;
        if (ctl !== C_RUN) begin
            fails++;
            $display("FAIL fwd_ctl got=%b exp=%b", ctl, C_RUN);
        end
        tick();
    endtask

    task automatic test_load_use;
        idle();
        ex_valid = 1'b1; ex_memread = 1'b1; ex_rd = 3'd2;
        id_rs2 = 3'd2; id_use_rs2 = 1'b1;
        #1;
        checks++;
        if (ctl !== C_LU) begin
            fails++;
            $display("FAIL lu_stall got=%b exp=%b", ctl, C_LU);
        end
        tick();
        ex_valid = 1'b0;
        #1;
        checks++;
        if (ctl !== C_RUN) begin
            fails++;
            $display("FAIL lu_release got=%b exp=%b", ctl, C_RUN);
        end
        tick();
        ex_valid = 1'b1; id_use_rs2 = 1'b0;
        id_rs1 = 3'd2; id_use_rs1 = 1'b0;
        #1;
        checks++;
        if (ctl !== C_RUN) begin
            fails++;
            $display("FAIL lu_unused_src got=%b exp=%b", ctl, C_RUN);
        end
        id_use_rs1 = 1'b1; ex_rd = 3'd0; id_rs1 = 3'd0;
        #1;
        checks++;
        if (ctl !== C_RUN) begin
            fails++;
            $display("FAIL lu_r0 got=%b exp=%b", ctl, C_RUN);
        end
        ex_rd = 3'd4; id_rs1 = 3'd4;
        #1;
        checks++;
        if (ctl !== C_LU) begin
            fails++;
            $display("FAIL lu_rs1 got=%b exp=%b", ctl, C_LU);
        end
        tick();
        idle();
        tick();
    endtask

    task automatic test_branch;
        idle();
        ex_valid = 1'b1; ex_memread = 1'b1; ex_rd = 3'd2;
        id_rs1 = 3'd2; id_use_rs1 = 1'b1;
        ex_branch_taken = 1'b1;
        #1;
        checks++;
        if (ctl !== C_BR) begin
            fails++;
            $display("FAIL br_over_lu got=%b exp=%b", ctl, C_BR);
        end
        tick();
        idle();
        ex_valid = 1'b1; ex_opcode = 4'b1011; ex_branch_taken = 1'b1;
        #1;
        checks++;
        if (ctl !== C_BR) begin
            fails++;
            $display("FAIL br_over_mul got=%b exp=%b", ctl, C_BR);
        end
        tick();
        idle();
        #1;
        checks++;
        if (ctl !== C_RUN) begin
            fails++;
            $display("FAIL br_after got=%b exp=%b", ctl, C_RUN);
        end
        tick();
    endtask

    task automatic test_mul;
        idle();
        ex_valid = 1'b1; ex_opcode = 4'b1011;
        ex_rs1 = 3'd3; mem_rd = 3'd3; mem_regwrite = 1'b1;
        wb_rd = 3'd3; wb_regwrite = 1'b1;
        ex_memread = 1'b0;
        id_rs1 = 3'd3; id_use_rs1 = 1'b1; ex_rd = 3'd3;
        #1;
        checks++;
        if (ctl !== C_START || forward_a !== 2'b10) begin
            fails++;
            $display("FAIL mul_start got=%b/%b exp=%b/10", ctl, forward_a, C_START);
        end
        tick();
        mem_regwrite = 1'b0;
        #1;
        checks++;
        if (ctl !== C_MBUB || forward_a !== 2'b10) begin
            fails++;
            $display("FAIL mul_multi1 got=%b/%b exp=%b/10", ctl, forward_a, C_MBUB);
        end
        tick();
        checks++;
        if (ctl !== C_MLAST || forward_a !== 2'b10) begin
            fails++;
            $display("FAIL mul_last got=%b/%b exp=%b/10", ctl, forward_a, C_MLAST);
        end
        tick();
        checks++;
        if (ctl !== C_RUN || forward_a !== 2'b01) begin
            fails++;
            $display("FAIL mul_done got=%b/%b exp=%b/01", ctl, forward_a, C_RUN);
        end
        tick();
        ex_valid = 1'b0;
        #1;
        checks++;
        if (ctl !== C_RUN) begin
            fails++;
            $display("FAIL mul_after got=%b exp=%b", ctl, C_RUN);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        idle();
        ex_valid = 1'b1; ex_opcode = 4'b1011;
        tick(); tick(); tick();
        checks++;
        if (ctl !== C_RUN) begin
            fails++;
            $display("FAIL b2b_done got=%b exp=%b", ctl, C_RUN);
        end
        tick();
        checks++;
        if (ctl !== C_START) begin
            fails++;
            $display("FAIL b2b_restart got=%b exp=%b", ctl, C_START);
        end
        tick(); tick(); tick();
        ex_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_multi;
        idle();
        ex_valid = 1'b1; ex_opcode = 4'b1011;
        tick();
        checks++;
        if (ctl !== C_MBUB) begin
            fails++;
            $display("FAIL rm_multi got=%b exp=%b", ctl, C_MBUB);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ctl !== C_ZERO) begin
            fails++;
            $display("FAIL rm_reset got=%b exp=%b", ctl, C_ZERO);
        end
        tick();
        rst_n = 1'b1;
        ex_valid = 1'b0;
        #1;
        checks++;
        if (ctl !== C_RUN) begin
            fails++;
            $display("FAIL rm_resume got=%b exp=%b", ctl, C_RUN);
        end
        tick();
    endtask

`ifdef HAZARD_CTRL_PERF_EN
    task automatic test_perf;
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int m = 0; m < 2; m++) begin
            ex_valid = 1'b1; ex_opcode = 4'b1011;
            tick(); tick(); tick(); tick();
            ex_valid = 1'b0;
            tick();
        end
        ex_valid = 1'b1; ex_opcode = 4'b0000;
        ex_memread = 1'b1; ex_rd = 3'd2;
        id_rs2 = 3'd2; id_use_rs2 = 1'b1;
        tick();
        idle();
        ex_branch_taken = 1'b1;
        tick();
        idle();
        tick();
        checks++;
        if (perf_mul_cnt !== 16'd2) begin
            fails++;
            $display("FAIL perf_mul got=%0d exp=2", perf_mul_cnt);
        end
        checks++;
        if (perf_stall_cnt !== 16'd7) begin
            fails++;
            $display("FAIL perf_stall got=%0d exp=7", perf_stall_cnt);
        end
        checks++;
        if (perf_flush_cnt !== 16'd1) begin
            fails++;
            $display("FAIL perf_flush got=%0d exp=1", perf_flush_cnt);
        end
        force dut.perf_mul_q = 16'hFFFF;
        #1;
        release dut.perf_mul_q;
        ex_valid = 1'b1; ex_opcode = 4'b1011;
        tick(); tick(); tick(); tick();
        ex_valid = 1'b0;
        tick();
        checks++;
        if (perf_mul_cnt !== 16'hFFFF) begin
            fails++;
            $display("FAIL perf_sat got=%h exp=ffff", perf_mul_cnt);
        end
    endtask
`endif

    initial begin
        idle();
        rst_n = 1'b0;
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_mul();
        test_back_to_back();
        test_reset_multi();
`ifdef HAZARD_CTRL_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
